activate: RTL

- Downstream neighbour of the multiply-accumulate stage. Consumes one forward accumulation vector of NC lanes, each (clog2(NP)+WF) bits.
- Applies a saturating ReLU to each lane. Emits two outputs:
  - a WF-bit state vector, which is the next layer's State0 input;
  - an NC-bit derivative mask, used by the backward path.
- Input and outputs use valid/ready handshakes. The input is forked to both outputs, and each output channel is independently buffered.

---
 rtl/activate_pkg.sv | 16 +
 rtl/activate_lane.sv | 36 +++
 rtl/activate.sv | 106 ++++++++++
 3 files changed

// File: rtl/activate_pkg.sv
// Shared constants and width helpers for the activate stage and its lane slice.
package activate_pkg;

  localparam logic [23:0] BURST_YES = "yes";
  localparam logic [23:0] BURST_NO  = "no";

  // Accumulator lane width; $clog2(1) = 0, so a single-input producer keeps WF.
  function automatic int acc_width(input int np, input int wf);
    return $clog2(np) + wf;
  endfunction

  function automatic int lane_max(input int wf);
    return (1 << (wf - 1)) - 1;
  endfunction

endpackage

// File: rtl/activate_lane.sv
// One saturating-ReLU lane: signed accumulator in, clamped state and derivative bit out.
module activate_lane
  import activate_pkg::*;
#(
  parameter int WA = 6,
  parameter int WF = 4
) (
  input  logic [WA-1:0] acc_i,
  output logic [WF-1:0] state_o,
  output logic          deriv_o
);

  localparam logic signed [WA-1:0] ZERO_A = '0;
  localparam logic signed [WA-1:0] MAX_A  = WA'(lane_max(WF));
  localparam logic        [WF-1:0] MAX_S  = WF'(lane_max(WF));

  logic signed [WA-1:0] acc_s;
  assign acc_s = $signed(acc_i);

  always_comb begin
    state_o = '0;
    deriv_o = 1'b0;
    if (acc_s <= ZERO_A) begin
      state_o = '0;
      deriv_o = 1'b0;
    end else if (acc_s > MAX_A) begin
      // Saturated lanes report zero slope to the backward path.
      state_o = MAX_S;
      deriv_o = 1'b0;
    end else begin
      state_o = acc_s[WF-1:0];
      deriv_o = 1'b1;
    end
  end

endmodule

// File: rtl/activate.sv
// ReLU activation stage: forks each accepted accumulation vector into independently
// buffered state and derivative channels, one entry each.
module activate
  import activate_pkg::*;
#(
  parameter int          NP    = 4,
  parameter int          NC    = 4,
  parameter int          WF    = 4,
  parameter logic [23:0] BURST = BURST_YES,
  localparam int         WA    = acc_width(NP, WF)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM_Accum,
  output logic             oReady_AM_Accum,
  input  logic [NC*WA-1:0] iData_AM_Accum,
  output logic             oValid_BM_State,
  input  logic             iReady_BM_State,
  output logic [NC*WF-1:0] oData_BM_State,
  output logic             oValid_BM_Deriv,
  input  logic             iReady_BM_Deriv,
  output logic [NC-1:0]    oData_BM_Deriv
);

  logic [NC*WF-1:0] lane_state;
  logic [NC-1:0]    lane_deriv;

  for (genvar k = 0; k < NC; k++) begin : g_lane
    activate_lane #(
      .WA(WA),
      .WF(WF)
    ) u_lane (
      .acc_i  (iData_AM_Accum[k*WA +: WA]),
      .state_o(lane_state[k*WF +: WF]),
      .deriv_o(lane_deriv[k])
    );
  end

  logic [NC*WF-1:0] state_q, state_d;
  logic [NC-1:0]    deriv_q, deriv_d;
  logic             fs_q, fs_d;
  logic             fd_q, fd_d;
  logic             s_free, d_free, fire;

  assign s_free = !fs_q || iReady_BM_State;
  assign d_free = !fd_q || iReady_BM_Deriv;
  assign fire   = iValid_AM_Accum && oReady_AM_Accum;

  if (BURST == BURST_YES) begin : g_burst
    assign oReady_AM_Accum = s_free && d_free && !iRST;
  end else begin : g_paced
    logic ready_q, ready_d;

    // Re-arm only after a cycle with no fire in which both channels were free,
    // so the flags are guaranteed clear whenever ready is presented.
    always_comb begin
      ready_d = 1'b0;
      if (!fire) ready_d = s_free && d_free;
    end

    always_ff @(posedge iCLK) begin
      if (iRST) ready_q <= 1'b0;
      else      ready_q <= ready_d;
    end

    assign oReady_AM_Accum = ready_q && !iRST;
  end

  always_comb begin
    // NOTE: every _d takes its held value first, so no path leaves one unassigned (no latches).
    state_d = state_q;
    deriv_d = deriv_q;
    fs_d    = fs_q;
    fd_d    = fd_q;
    if (fire) begin
      state_d = lane_state;
      deriv_d = lane_deriv;
      fs_d    = 1'b1;
      fd_d    = 1'b1;
    end else begin
      if (fs_q && iReady_BM_State) fs_d = 1'b0;
      if (fd_q && iReady_BM_Deriv) fd_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    // NOTE: non-blocking updates keep every flop sampling pre-edge values.
    if (iRST) begin
      state_q <= '0;
      deriv_q <= '0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      deriv_q <= deriv_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  assign oValid_BM_State = fs_q;
  assign oValid_BM_Deriv = fd_q;
  assign oData_BM_State  = state_q;
  assign oData_BM_Deriv  = deriv_q;

endmodule
